ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit beside the EX-stage ALU, with architectural HI/LO registers.
- Handles MULT, MULTU, DIV and DIVU at a parametrised data width.
- Holds the pipeline via stallreq while busy and pulses done when HI/LO are updated.
- Supports flush-driven cancellation and direct HI/LO writes (MTHI/MTLO).

---
 rtl/ex_muldiv_unit.sv | 215 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; done lands DATA_W+1 edges after accept (2 for div-by-zero or fast multiply).
// Holds the pipeline via combinational stallreq while busy; cancel aborts; optional MULDIV_FAST_MUL_EN enables single-cycle multiply.
module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              stallreq,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 2);

    state_t              state_q, state_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                is_div_q, is_div_d;
    logic                raw_q, raw_d;
    logic                dbz_q, dbz_d;
    logic                done_q, done_d;
    logic                dbz_out_q, dbz_out_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                accept;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [2*DATA_W-1:0] fin_res;

    // Multiplier lives in the low half and shifts out as the product shifts in.
    function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0]   mcand);
        logic [DATA_W:0] sum;
        sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? mcand : {DATA_W{1'b0}})};
        return {sum, acc[DATA_W-1:1]};
    endfunction

    // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
    function automatic logic [2*DATA_W-1:0] div_step(input logic [2*DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0]   dvsr);
        logic [DATA_W:0] part;
        logic [DATA_W:0] diff;
        part = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        diff = part - {1'b0, dvsr};
        if (!diff[DATA_W]) begin
            return {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end
        return {part[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    endfunction

    assign accept   = (state_q == S_IDLE) && op_valid && !cancel;
    assign sign_a   = !op[0] && src_a[DATA_W-1];
    assign sign_b   = !op[0] && src_b[DATA_W-1];
    assign mag_a    = sign_a ? -src_a : src_a;
    assign mag_b    = sign_b ? -src_b : src_b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
    // Low 2*DATA_W bits of an extended product are correct for signed and unsigned alike.
    assign ext_a     = {{DATA_W{sign_a}}, src_a};
    assign ext_b     = {{DATA_W{sign_b}}, src_b};
    assign fast_prod = ext_a * ext_b;
`endif

    always_comb begin
        fin_res = acc_q;
        if (!raw_q) begin
            if (is_div_q) begin
                fin_res[2*DATA_W-1:DATA_W] = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W]
                                                       : acc_q[2*DATA_W-1:DATA_W];
                fin_res[DATA_W-1:0]        = neg_quo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
            end else if (neg_quo_q) begin
                fin_res = -acc_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        raw_d     = raw_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (accept) begin
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    is_div_d  = op[1];
                    cnt_d     = '0;
                    raw_d     = 1'b0;
                    dbz_d     = 1'b0;
                    // The accepting edge already performs the first iteration.
                    if (op[1]) begin
                        opnd_d = mag_b;
                        if (src_b == '0) begin
                            acc_d   = {src_a, {DATA_W{1'b1}}};
                            raw_d   = 1'b1;
                            dbz_d   = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            acc_d   = div_step({{DATA_W{1'b0}}, mag_a}, mag_b);
                            state_d = S_DIV;
                        end
                    end else begin
                        opnd_d = mag_a;
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = fast_prod;
                        raw_d   = 1'b1;
                        state_d = S_FIN;
`else
                        acc_d   = mul_step({{DATA_W{1'b0}}, mag_b}, mag_a);
                        state_d = S_MUL;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_step(acc_q, opnd_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) state_d = S_FIN;
            end
            S_DIV: begin
                acc_d = div_step(acc_q, opnd_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) state_d = S_FIN;
            end
            S_FIN: begin
                hi_d      = fin_res[2*DATA_W-1:DATA_W];
                lo_d      = fin_res[DATA_W-1:0];
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cancel && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            dbz_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            raw_q     <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            raw_q     <= raw_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign stallreq    = (state_q != S_IDLE) || accept;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed plus randomized checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         cancel;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         ready, stallreq, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int vectors    = 0;
    int miscompares = 0;

    ex_muldiv_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .ready(ready), .stallreq(stallreq), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} computed from plain signed/unsigned arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b11) return {1'b0, a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
                return {1'b0, ia % ib, ia / ib};
            end
        endcase
    endfunction

    // Waits (bounded) for done; busy_ok tracks stallreq high and div_by_zero low before it.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int n = 2; n < 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (!stallreq || div_by_zero) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [64:0] exp;
        int          lat;
        int          exp_lat;
        bit          busy_ok;
        exp     = model(o, a, b);
        exp_lat = o[1] ? ((b == '0) ? 2 : W + 1) : MUL_LAT;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk({tag, ".stall_accept"}, 64'(stallreq), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        wait_done(lat, busy_ok);
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
        chk({tag, ".stall_done"}, 64'(stallreq), 64'd0);
        chk({tag, ".hilo"}, {hi, lo}, exp[63:0]);
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp[64]));
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        bit          busy_ok;
        bit          seen_done;
        logic [W-1:0] ra, rb;
        logic [1:0]   ro;

        rst_n = 1'b0; op_valid = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #2;
        chk("reset.ready", 64'(ready), 64'd1);
        chk("reset.stall", 64'(stallreq), 64'd0);
        chk("reset.hilo", {hi, lo}, 64'd0);
        chk("reset.flags", {62'd0, done, div_by_zero}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minbym1");
        run_op(2'b10, 32'h0000_1234, 32'd0, "div_by_zero");
        run_op(2'b11, 32'd7, 32'd2, "divu_7by2");

        // Cancel mid-divide; a HI write while busy must be dropped.
        op_valid = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        hi_we = 1'b0;
        cancel = 1'b1;
        chk("cancel.busy_before", 64'(ready), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel.ready_next", 64'(ready), 64'd1);
        chk("cancel.hilo_kept", {hi, lo}, {32'd1, 32'd3});
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        chk("cancel.no_done", 64'(seen_done), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, "divu_reissue");

        // Cancel in IDLE blocks acceptance.
        op_valid = 1'b1; cancel = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        #1;
        chk("idle_cancel.stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        chk("idle_cancel.ready", 64'(ready), 64'd1);
        op_valid = 1'b0; cancel = 1'b0;

        // Direct HI/LO writes.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo.both", {hi, lo}, {32'h1357_9BDF, 32'h1357_9BDF});
        lo_we = 1'b1; wdata = 32'h0000_00AA;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo.only", {hi, lo}, {32'h1357_9BDF, 32'h0000_00AA});

        // Write coinciding with acceptance lands, then the result overwrites it.
        op_valid = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd4;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        op_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("accept_write.landed", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        wait_done(lat, busy_ok);
        chk("accept_write.latency", 64'(lat), 64'(MUL_LAT));
        chk("accept_write.result", {hi, lo}, {32'd0, 32'd12});

        // Asynchronous reset in the middle of a multiply.
        op_valid = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'h7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.hilo", {hi, lo}, 64'd0);
        chk("midreset.ready", 64'(ready), 64'd1);
        chk("midreset.stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'd3, 32'd4, "multu_after_reset");

        for (int t = 0; t < 30; t++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
